// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches sysid words 0 (ID) and 1 (timestamp),
// compares them with build-time values and keeps a saturating failure count.
// Optional macro SYSID_CHECK_AUTOSTART_EN launches one check right after reset release.
//   state | meaning
//   IDLE  | waiting for start, address parked on word 0
//   RD_ID | address 0 held READ_LATENCY+1 cycles, ID captured on the last edge
//   RD_TS | address 1 held READ_LATENCY+1 cycles, timestamp captured on the last edge
//   CMP   | flags and fail count registered, done pulses in the following cycle
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd7,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1381349107,
  parameter int unsigned READ_LATENCY       = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts,
  output logic [7:0]  fail_count
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, CMP} state_t;

  localparam logic [3:0] LAST = 4'(READ_LATENCY);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] cap_id_q, cap_id_d;
  logic [31:0] cap_ts_q, cap_ts_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        match_q, match_d;
  logic [7:0]  fail_q, fail_d;
  logic        done_q, done_d;
  logic        go;
  logic        id_hit, ts_hit;

`ifdef SYSID_CHECK_AUTOSTART_EN
  // Set by reset, cleared after the first clock: acts as a one-shot start.
  logic auto_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_q <= 1'b1;
    else          auto_q <= 1'b0;
  end

  assign go = start | auto_q;
`else
  assign go = start;
`endif

  assign id_hit = (cap_id_q == EXPECTED_ID);
  assign ts_hit = (cap_ts_q == EXPECTED_TIMESTAMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cap_id_q <= 32'd0;
      cap_ts_q <= 32'd0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      match_q  <= 1'b0;
      fail_q   <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      match_q  <= match_d;
      fail_q   <= fail_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    match_d  = match_q;
    fail_d   = fail_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = RD_ID;
          cnt_d   = 4'd0;
        end
      end
      RD_ID: begin
        if (cnt_q == LAST) begin
          cap_id_d = sysid_readdata;
          cnt_d    = 4'd0;
          state_d  = RD_TS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_TS: begin
        if (cnt_q == LAST) begin
          cap_ts_d = sysid_readdata;
          cnt_d    = 4'd0;
          state_d  = CMP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CMP: begin
        id_ok_d = id_hit;
        ts_ok_d = ts_hit;
        match_d = id_hit & ts_hit;
        if (!(id_hit && ts_hit) && (fail_q != 8'hFF)) fail_d = fail_q + 8'd1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sysid_address = (state_q == RD_TS);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign match         = match_q;
  assign captured_id   = cap_id_q;
  assign captured_ts   = cap_ts_q;
  assign fail_count    = fail_q;

endmodule

// File: doc/sysid_checker.md
# sysid_checker

Avalon-MM read master that sits directly upstream of the system ID slave: it drives the slave's 1-bit word address and consumes its 32-bit readdata. On each check request it reads word 0 (system ID) and word 1 (build timestamp), compares both against build-time expected values, and reports pass/fail flags plus a saturating failure count. Boot logic and the host use it to confirm that the loaded FPGA image matches the software build before the CPU is released.

## Interface
- EXPECTED_ID, 32'd7, expected value of sysid word 0
- EXPECTED_TIMESTAMP, 32'd1381349107, expected value of sysid word 1
- READ_LATENCY, 0, cycles from address change to valid readdata (0 = combinational slave); legal range 0..15

- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  check request, sampled high in IDLE only
- sysid_address  out  1  word address to the sysid slave (0 = ID, 1 = timestamp)
- sysid_readdata  in  32  readdata from the sysid slave
- busy  out  1  high while a check is in progress
- done  out  1  one-cycle pulse when results update
- id_ok  out  1  captured ID equals EXPECTED_ID
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP
- match  out  1  id_ok AND ts_ok
- captured_id  out  32  last sampled word 0
- captured_ts  out  32  last sampled word 1
- fail_count  out  8  number of completed checks with match = 0, saturates at 255

## Operation
- States: IDLE, RD_ID, RD_TS, CMP.
- IDLE: sysid_address = 0, busy = 0. start = 1 -> RD_ID, wait counter cleared.
- RD_ID: sysid_address = 0; held for READ_LATENCY+1 cycles; on the last cycle's edge captured_id <= sysid_readdata, counter cleared, -> RD_TS.
- RD_TS: sysid_address = 1; held for READ_LATENCY+1 cycles; on the last edge captured_ts <= sysid_readdata, -> CMP.
- CMP: registers id_ok, ts_ok and match from the captured words; if mismatch and fail_count < 255, increments fail_count; -> IDLE and asserts done for exactly the next cycle.
- Flags and captured words hold their values until the next CMP; they are not cleared by start.
- Wait counter is 4 bits and runs 0..READ_LATENCY.

## Timing
- Reset values: sysid_address 0, busy 0, done 0, id_ok 0, ts_ok 0, match 0, captured_id 0, captured_ts 0, fail_count 0, state IDLE.
- start sampled high in cycle 0 -> busy high in cycles 1 through 2(L+1)+1, where L = READ_LATENCY; done high in cycle 2(L+1)+2, with the new flags valid in that same cycle.
- L = 0: RD_ID in cycle 1, RD_TS in cycle 2, CMP in cycle 3, done in cycle 4.
- start while busy: ignored; no queuing.
- start high in the done cycle: accepted (state is IDLE), so back-to-back checks run every 2(L+1)+2 cycles.
- start held high continuously: repeats checks back to back.
- Reset asserted mid-check: all outputs return to their reset values immediately (asynchronously); no done pulse is issued; fail_count is cleared.
- fail_count at 255 plus another mismatch: stays 255; match still reports 0.

## Configuration
- SYSID_CHECK_AUTOSTART_EN defined: one check starts automatically in the first cycle after reset_n deasserts, as if start had been sampled high in that cycle. It fires once per reset; the start input still works afterwards.
- Not defined: checks run only on start; after reset the block stays in IDLE.

## Test plan
- L=0, slave returns 7 / 1381349107, start pulse in cycle 0 -> done in cycle 4; id_ok=1, ts_ok=1, match=1; fail_count=0; address sequence 0,0,1,0.
- L=2, slave returns word0=7, word1=0x12345678 -> done in cycle 8; id_ok=1, ts_ok=0, match=0, captured_ts=0x12345678, fail_count=1.
- start re-pulsed in cycles 1–3 during a check -> exactly one done, in cycle 4; fail_count changes by at most 1.
- reset_n pulled low in cycle 2 of a check with mismatching data -> all outputs 0 immediately, no done, fail_count=0; a fresh start afterwards completes normally.
- 260 consecutive mismatching checks with start held high -> fail_count=255 and stays there; done pulses every 4 cycles at L=0.
- SYSID_CHECK_AUTOSTART_EN defined, start tied low -> one check completes, done 4 cycles after the first post-reset cycle at L=0, and no further checks follow.
